network_interface: RTL
======================

NETWORK_INTERFACE -- requirements
Module: network_interface

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- X_LOC, 0, node X coordinate; stamped as source X.
- Y_LOC, 0, node Y coordinate; stamped as source Y.
- INJ_DEPTH, 4, injection queue entries; power of two, at least 2.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- reset_n, in, 1, asynchronous active-low reset.
- i_pe_data, in, packet_t, packet from PE.
- i_pe_data_val, in, 1, PE packet valid.
- o_pe_en, out, 1, injection queue can accept.
- o_router_data, out, packet_t, packet to router local input.
- o_router_data_val, out, 1, router-bound packet valid.
- i_router_en, in, 1, router local input can accept.
- i_router_data, in, packet_t, packet from router local output.
- i_router_data_val, in, 1, router packet valid.
- o_router_en, out, 1, ejection buffer can accept.
- o_pe_data, out, packet_t, ejected packet to PE.
- o_pe_data_val, out, 1, ejected packet valid.
- i_pe_en, in, 1, PE can accept.
- o_sent_count, out, 32, packets handed to router.
- o_recv_count, out, 32, packets captured from router.
- o_latency_sum, out, 32, saturating sum of packet latencies.
- o_misroute, out, 1, sticky flag: a packet arrived for another node.

Function
REQ-003 Accept rule SHALL be the same at both sides: a transfer occurs when valid is high in a cycle where the receiver's enable is high.
REQ-004 A free-running counter ts_now SHALL be TS_WIDTH bits wide, increment every cycle and wrap to 0.
REQ-005 On an injection push (i_pe_data_val and o_pe_en), the stored packet SHALL have:
- x_source = X_LOC and y_source = Y_LOC;
- timestamp = ts_now;
- all other fields unchanged.
REQ-006 o_pe_en SHALL be high when the injection count is below INJ_DEPTH, decoded from registered state. There is no push while full, even if a pop occurs in that cycle.
REQ-007 o_router_data SHALL always show the injection queue head.
- o_router_data_val = (queue not empty) and i_router_en.
- A pop occurs whenever o_router_data_val is high.
REQ-008 Injection latency SHALL be 1 cycle: a packet pushed in cycle t is first presentable in cycle t+1, with no combinational bypass.
REQ-009 A simultaneous push and pop SHALL leave the count unchanged. Pointers SHALL wrap modulo INJ_DEPTH.
REQ-010 The ejection buffer SHALL be a 2-entry FIFO.
- o_router_en = count < 2, decoded from registered state.
- Capture occurs when i_router_data_val and o_router_en.
REQ-011 Ejection output SHALL follow the injection rules.
- o_pe_data = head; o_pe_data_val = (not empty) and i_pe_en; pop when o_pe_data_val.
- Capture-to-valid latency is 1 cycle; simultaneous capture and pop keep the count.
REQ-012 On capture, latency = (ts_now - timestamp) mod 2^TS_WIDTH.
- o_latency_sum += latency, saturating at 0xFFFF_FFFF.
- o_recv_count += 1, wrapping.
REQ-013 o_sent_count SHALL increment (wrapping) on every injection pop.
REQ-014 If a captured packet has (x_dest, y_dest) != (X_LOC, Y_LOC), o_misroute SHALL set and stay set until reset. The packet SHALL still be delivered.
REQ-015 All statistic outputs SHALL be registered, updated the cycle after the triggering transfer.

Reset
REQ-016 reset_n low SHALL asynchronously clear all of the following, including when asserted mid-transfer, with all in-flight packets discarded:
- queues;
- ts_now;
- counters, o_latency_sum and o_misroute.
REQ-017 During reset, outputs SHALL be:
- o_router_data_val = 0 and o_pe_data_val = 0;
- o_pe_en = 1 and o_router_en = 1;
- statistics = 0.

Structure
REQ-018 packet_t (fields x_source, y_source, x_dest, y_dest, timestamp) and TS_WIDTH SHALL reside in the shared config package.
REQ-019 One sub-module, ni_queue (parameter DEPTH; push/pop FIFO of packet_t with count), SHALL be instantiated twice: DEPTH = INJ_DEPTH and DEPTH = 2.
REQ-020 Stamping, the latency arithmetic and the statistics SHALL live in the top level.

Verification
REQ-021 Single injection: X_LOC=1, Y_LOC=2, i_router_en=1, push at ts_now=5 -> o_router_data_val in the next cycle with x_source=1, y_source=2, timestamp=5; o_sent_count=1 one cycle later.
REQ-022 Backpressure: i_router_en=0, push 5 packets with INJ_DEPTH=4 -> o_pe_en drops after the 4th; the 5th is not accepted. Release -> 4 pops in order, o_sent_count=4.
REQ-023 Simultaneous push and pop at count 2 -> count stays 2, order preserved. Pointer wrap is exercised over 10 packets.
REQ-024 Ejection latency: capture timestamp=3 at ts_now=10 -> o_latency_sum=7, o_recv_count=1. Capture timestamp=2^TS_WIDTH-2 at ts_now=1 -> latency 3.
REQ-025 Saturation and misroute: preload sum near the maximum and add 20 -> sum = 0xFFFF_FFFF. Packet with x_dest=X_LOC+1 -> o_misroute=1, packet still delivered to the PE.
REQ-026 Reset: assert reset_n mid-stream with i_pe_en=0 and both queues holding data -> all valids 0 and stats 0 immediately. After release, the first new packet is stamped ts relative to 0.

Source files
------------

// File: rtl/network_interface_pkg.sv
// Shared definitions for the network interface: packet layout, timestamp
// width and the saturating accumulator used for latency statistics.
package network_interface_pkg;

    // Width of the free-running timestamp counter and packet timestamp field.
    localparam int TS_WIDTH    = 8;
    // Width of every X/Y coordinate field in a packet.
    localparam int COORD_WIDTH = 4;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] x_source;
        logic [COORD_WIDTH-1:0] y_source;
        logic [COORD_WIDTH-1:0] x_dest;
        logic [COORD_WIDTH-1:0] y_dest;
        logic [TS_WIDTH-1:0]    timestamp;
    } packet_t;

    // Add a latency sample to a 32-bit accumulator, clamping at all-ones
    // instead of wrapping so a long run never reports a small total.
    function automatic logic [31:0] sat_add32(input logic [31:0]         acc,
                                              input logic [TS_WIDTH-1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, acc} + {{(33 - TS_WIDTH){1'b0}}, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/network_interface_queue.sv
// ni_queue: circular FIFO of packet_t with an occupancy count.
// Pushes while full and pops while empty are ignored, so callers may
// derive their enables from count_o without extra guarding. The head
// entry is read straight from storage; a packet pushed in one cycle is
// visible at head_o from the next cycle on (no write-through bypass).
module ni_queue
    import network_interface_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  packet_t                push_data_i,
    input  logic                   pop_i,
    output packet_t                head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    packet_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers and count; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards any queued packets.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Packet storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/network_interface.sv
// Network interface between a processing element (PE) and its router's
// local port. Injection: PE packets are stamped with this node's
// coordinates and the current time, queued, and presented to the router.
// Ejection: router packets are captured into a 2-entry buffer and handed
// to the PE, while latency, counts and a sticky misroute flag are kept.
//
// Handshake on every link: the sender shows data with a valid flag, the
// receiver shows an enable; a transfer happens in exactly the cycles where
// valid and enable are both high. Enables come from registered occupancy
// only, and outgoing valids already include the downstream enable, so a
// high outgoing valid always means a transfer in that cycle.
module network_interface
    import network_interface_pkg::*;
#(
    parameter int X_LOC     = 0,
    parameter int Y_LOC     = 0,
    parameter int INJ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  packet_t     i_pe_data,
    input  logic        i_pe_data_val,
    output logic        o_pe_en,
    output packet_t     o_router_data,
    output logic        o_router_data_val,
    input  logic        i_router_en,
    input  packet_t     i_router_data,
    input  logic        i_router_data_val,
    output logic        o_router_en,
    output packet_t     o_pe_data,
    output logic        o_pe_data_val,
    input  logic        i_pe_en,
    output logic [31:0] o_sent_count,
    output logic [31:0] o_recv_count,
    output logic [31:0] o_latency_sum,
    output logic        o_misroute
);
    localparam int INJ_CW   = $clog2(INJ_DEPTH) + 1;
    localparam int EJ_DEPTH = 2;
    localparam int EJ_CW    = $clog2(EJ_DEPTH) + 1;

    localparam logic [COORD_WIDTH-1:0] LOC_X = COORD_WIDTH'(X_LOC);
    localparam logic [COORD_WIDTH-1:0] LOC_Y = COORD_WIDTH'(Y_LOC);

    // Time base
    logic [TS_WIDTH-1:0] ts_now_q, ts_now_d;

    // Injection path
    packet_t             inj_push_data;
    logic                inj_push;
    logic                inj_pop;
    logic [INJ_CW-1:0]   inj_count;

    // Ejection path
    logic                ej_capture;
    logic                ej_pop;
    logic [EJ_CW-1:0]    ej_count;
    logic [TS_WIDTH-1:0] capture_latency;
    logic                capture_foreign;

    // Statistics
    logic [31:0]         sent_count_q, sent_count_d;
    logic [31:0]         recv_count_q, recv_count_d;
    logic [31:0]         latency_sum_q, latency_sum_d;
    logic                misroute_q, misroute_d;

    // ------------------------------------------------------------------
    // Time base
    // ------------------------------------------------------------------

    // Free-running timestamp, wraps modulo 2^TS_WIDTH.
    always_comb begin
        ts_now_d = ts_now_q + 1'b1;
    end

    // Timestamp register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_now_q <= '0;
        end else begin
            ts_now_q <= ts_now_d;
        end
    end

    // ------------------------------------------------------------------
    // Injection: PE -> queue -> router
    // ------------------------------------------------------------------

    // Stamp source coordinates and injection time; dest fields pass through.
    always_comb begin
        inj_push_data           = i_pe_data;
        inj_push_data.x_source  = LOC_X;
        inj_push_data.y_source  = LOC_Y;
        inj_push_data.timestamp = ts_now_q;
    end

    // Full is judged on the registered count only: a pop in the same cycle
    // does not reopen the queue until the next cycle.
    assign o_pe_en           = (inj_count < INJ_CW'(INJ_DEPTH));
    assign inj_push          = i_pe_data_val && o_pe_en;
    assign o_router_data_val = (inj_count != '0) && i_router_en;
    assign inj_pop           = o_router_data_val;

    ni_queue #(
        .DEPTH (INJ_DEPTH)
    ) u_inj_queue (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (inj_push),
        .push_data_i (inj_push_data),
        .pop_i       (inj_pop),
        .head_o      (o_router_data),
        .count_o     (inj_count)
    );

    // ------------------------------------------------------------------
    // Ejection: router -> buffer -> PE
    // ------------------------------------------------------------------

    assign o_router_en   = (ej_count < EJ_CW'(EJ_DEPTH));
    assign ej_capture    = i_router_data_val && o_router_en;
    assign o_pe_data_val = (ej_count != '0) && i_pe_en;
    assign ej_pop        = o_pe_data_val;

    ni_queue #(
        .DEPTH (EJ_DEPTH)
    ) u_ej_queue (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (ej_capture),
        .push_data_i (i_router_data),
        .pop_i       (ej_pop),
        .head_o      (o_pe_data),
        .count_o     (ej_count)
    );

    // Network latency of the arriving packet (modular, so wrap is harmless)
    // and whether it was addressed to some other node.
    always_comb begin
        capture_latency = ts_now_q - i_router_data.timestamp;
        capture_foreign = (i_router_data.x_dest != LOC_X) ||
                          (i_router_data.y_dest != LOC_Y);
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------

    // Next statistic values from this cycle's transfers.
    always_comb begin
        sent_count_d  = sent_count_q;
        recv_count_d  = recv_count_q;
        latency_sum_d = latency_sum_q;
        misroute_d    = misroute_q;
        if (inj_pop) begin
            sent_count_d = sent_count_q + 32'd1;
        end
        if (ej_capture) begin
            recv_count_d  = recv_count_q + 32'd1;
            latency_sum_d = sat_add32(latency_sum_q, capture_latency);
            if (capture_foreign) begin
                misroute_d = 1'b1;
            end
        end
    end

    // Statistic registers; the misroute flag is sticky until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sent_count_q  <= '0;
            recv_count_q  <= '0;
            latency_sum_q <= '0;
            misroute_q    <= 1'b0;
        end else begin
            sent_count_q  <= sent_count_d;
            recv_count_q  <= recv_count_d;
            latency_sum_q <= latency_sum_d;
            misroute_q    <= misroute_d;
        end
    end

    assign o_sent_count  = sent_count_q;
    assign o_recv_count  = recv_count_q;
    assign o_latency_sum = latency_sum_q;
    assign o_misroute    = misroute_q;

endmodule
